// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache sitting between the
// memory stage and the SRAM controller. 64 sets of one 64-bit line each,
// indexed from the byte address after removing the 1024-byte base offset.
// Optional read hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_WAIT} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [63:0] valid;

    logic [9:0]  tag_mem  [64];
    logic [63:0] line_mem [64];

    logic [16:0] word_addr;
    logic [5:0]  idx;
    logic [9:0]  tag;
    logic        word_sel;
    logic        hit;
    logic [31:0] hit_word;
    logic [31:0] fill_word;
    logic        rd_hit;
    logic        fill_done;
    logic        wr_done;

    // Decode the active request: live inputs in IDLE, the captured request
    // otherwise. Only address bits 18:2 reach the fields, so the base offset
    // is removed on the word address (1024 bytes = 256 words).
    always_comb begin
        word_addr = (state == IDLE) ? address[18:2] : addr_q[18:2];
        word_addr = word_addr - 17'd256;
        word_sel  = word_addr[0];
        idx       = word_addr[6:1];
        tag       = word_addr[16:7];
        hit       = valid[idx] && (tag_mem[idx] == tag);
        hit_word  = word_sel ? line_mem[idx][63:32] : line_mem[idx][31:0];
        fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
        rd_hit    = (state == IDLE) && MEM_R_EN && !MEM_W_EN && hit;
        fill_done = (state == RD_MISS) && sram_ready;
        wr_done   = (state == WR_WAIT) && sram_ready;
    end

    // Handshake outputs: hits and completions answer in the same cycle, and
    // rdata falls back to the last word returned when nothing completes.
    always_comb begin
        sram_r_en    = (state == RD_MISS);
        sram_w_en    = (state == WR_WAIT);
        sram_address = (state == IDLE) ? address : addr_q;
        sram_wdata   = (state == IDLE) ? wdata : wdata_q;
        ready        = 1'b0;
        case (state)
            IDLE:    ready = !MEM_W_EN && (!MEM_R_EN || hit);
            RD_MISS: ready = sram_ready;
            WR_WAIT: ready = sram_ready;
            default: ready = 1'b0;
        endcase
        if (rd_hit)
            rdata = hit_word;
        else if (fill_done)
            rdata = fill_word;
        else
            rdata = rdata_q;
    end

    // Control FSM: captures the request on leaving IDLE, owns the valid bits
    // and the held read word; reset abandons any SRAM transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr_q  <= address;
                    wdata_q <= wdata;
                    if (MEM_W_EN)
                        state <= WR_WAIT;
                    else if (MEM_R_EN) begin
                        if (hit)
                            rdata_q <= hit_word;
                        else
                            state <= RD_MISS;
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        valid[idx] <= 1'b1;
                        rdata_q    <= fill_word;
                        state      <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (sram_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and line storage: refills write the whole line, write hits patch
    // one word; left unreset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[idx]  <= tag;
            line_mem[idx] <= sram_rdata;
        end else if (wr_done && hit) begin
            if (word_sel)
                line_mem[idx][63:32] <= wdata_q;
            else
                line_mem[idx][31:0]  <= wdata_q;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating read statistics: hits counted on the answering cycle,
    // misses when the refill completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (fill_done && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios followed by
// randomized reads and writes, checked against an array-based cache model
// computed from address arithmetic. Counter expectations follow CACHE_STATS_EN.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bit          mvalid [64];
    int unsigned mtag   [64];
    logic [63:0] mline  [64];
    int unsigned mhits  = 0;
    int unsigned mmiss  = 0;
    logic [31:0] last_rdata = '0;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_r_en    (sram_r_en),
        .sram_w_en    (sram_w_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cache geometry from plain arithmetic on the byte address.
    function automatic void fields(input logic [31:0] addr, output int unsigned idx,
                                   output int unsigned tg, output int unsigned wd);
        logic [31:0] a;
        a   = (addr & 32'hFFFF_FFFC) - 32'd1024;
        idx = (a / 8) % 64;
        tg  = (a / 512) % 1024;
        wd  = (a / 4) % 2;
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] r;
        if ($urandom_range(0, 19) == 0)
            r = $urandom;
        else
            r = 32'h400 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 31) << 2)
                + $urandom_range(0, 3);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One quiet cycle: no request, so ready is high and rdata holds.
    task automatic idleCheck();
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", ready, 1'b1);
        checkOutput("idle_rdata_hold", rdata, last_rdata);
        checkOutput("idle_sram_r_en", sram_r_en, 1'b0);
        checkOutput("idle_sram_w_en", sram_w_en, 1'b0);
        @(posedge clk); #1;
    endtask

    // Read request held until ready; the model decides hit or miss.
    task automatic applyStimulusRead(input logic [31:0] addr, input int lat, input logic [63:0] line);
        int unsigned idx, tg, wd;
        logic [31:0] exp;
        fields(addr, idx, tg, wd);
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        address  = addr;
        wdata    = $urandom;
        if (mvalid[idx] && mtag[idx] == tg) begin
            exp = (wd == 1) ? mline[idx][63:32] : mline[idx][31:0];
            @(negedge clk);
            checkOutput("hit_ready", ready, 1'b1);
            checkOutput("hit_rdata", rdata, exp);
            checkOutput("hit_sram_r_en", sram_r_en, 1'b0);
            @(posedge clk); #1;
            if (mhits < 65535) mhits++;
            last_rdata = exp;
        end else begin
            exp = (wd == 1) ? line[63:32] : line[31:0];
            @(negedge clk);
            checkOutput("miss_idle_ready", ready, 1'b0);
            @(posedge clk); #1;
            for (int c = 0; c < lat; c++) begin
                address = $urandom;
                @(negedge clk);
                checkOutput("miss_wait_r_en", sram_r_en, 1'b1);
                checkOutput("miss_wait_w_en", sram_w_en, 1'b0);
                checkOutput("miss_wait_ready", ready, 1'b0);
                @(posedge clk); #1;
            end
            sram_ready = 1'b1;
            sram_rdata = line;
            @(negedge clk);
            checkOutput("fill_ready", ready, 1'b1);
            checkOutput("fill_rdata", rdata, exp);
            checkOutput("fill_r_en", sram_r_en, 1'b1);
            checkOutput("fill_sram_address", sram_address, addr);
            @(posedge clk); #1;
            sram_ready  = 1'b0;
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            mline[idx]  = line;
            if (mmiss < 65535) mmiss++;
            last_rdata = exp;
        end
        MEM_R_EN = 1'b0;
    endtask

    // Write request (optionally with a competing read) held until ready.
    task automatic applyStimulusWrite(input logic [31:0] addr, input logic [31:0] data,
                                      input int lat, input bit both);
        int unsigned idx, tg, wd;
        fields(addr, idx, tg, wd);
        MEM_W_EN = 1'b1;
        MEM_R_EN = both;
        address  = addr;
        wdata    = data;
        @(negedge clk);
        checkOutput("wr_idle_ready", ready, 1'b0);
        checkOutput("wr_idle_r_en", sram_r_en, 1'b0);
        @(posedge clk); #1;
        for (int c = 0; c < lat; c++) begin
            address = $urandom;
            wdata   = $urandom;
            @(negedge clk);
            checkOutput("wr_wait_w_en", sram_w_en, 1'b1);
            checkOutput("wr_wait_r_en", sram_r_en, 1'b0);
            checkOutput("wr_wait_ready", ready, 1'b0);
            checkOutput("wr_wait_wdata", sram_wdata, data);
            @(posedge clk); #1;
        end
        sram_ready = 1'b1;
        sram_rdata = {$urandom, $urandom};
        @(negedge clk);
        checkOutput("wr_done_ready", ready, 1'b1);
        checkOutput("wr_done_w_en", sram_w_en, 1'b1);
        checkOutput("wr_done_address", sram_address, addr);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        MEM_W_EN   = 1'b0;
        MEM_R_EN   = 1'b0;
        if (mvalid[idx] && mtag[idx] == tg) begin
            if (wd == 1) mline[idx][63:32] = data;
            else         mline[idx][31:0]  = data;
        end
    endtask

    initial begin
        int unsigned exp_hits, exp_miss;
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        address    = '0;
        wdata      = '0;
        sram_rdata = '0;
        sram_ready = 1'b0;

        #3;
        checkOutput("reset_ready", ready, 1'b1);
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_r_en", sram_r_en, 1'b0);
        checkOutput("reset_w_en", sram_w_en, 1'b0);
        checkOutput("reset_hit_count", hit_count, 16'h0);
        checkOutput("reset_miss_count", miss_count, 16'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed scenarios");
        applyStimulusRead(32'h400, 3, 64'hBBBB_BBBB_AAAA_AAAA);
        idleCheck();
        checkOutput("dir_rd400", rdata, 32'hAAAA_AAAA);
        applyStimulusRead(32'h404, 0, 64'h0);
        checkOutput("dir_rd404", rdata, 32'hBBBB_BBBB);
        applyStimulusWrite(32'h404, 32'h1234_5678, 2, 1'b0);
        applyStimulusRead(32'h404, 0, 64'h0);
        idleCheck();
        checkOutput("dir_rd404_after_wr", rdata, 32'h1234_5678);
        applyStimulusRead(32'h600, 1, {$urandom, $urandom});
        applyStimulusRead(32'h400, 2, 64'h1111_2222_3333_4444);
        idleCheck();
        checkOutput("dir_rd400_refetch", rdata, 32'h3333_4444);
`ifdef CACHE_STATS_EN
        checkOutput("dir_hit_count", hit_count, 16'd2);
        checkOutput("dir_miss_count", miss_count, 16'd3);
`else
        checkOutput("dir_hit_count", hit_count, 16'd0);
        checkOutput("dir_miss_count", miss_count, 16'd0);
`endif

        $display("[TB] reset during refill");
        MEM_R_EN = 1'b1;
        address  = 32'h600;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_pre_r_en", sram_r_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_r_en", sram_r_en, 1'b0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_hit_count", hit_count, 16'h0);
        checkOutput("rst_miss_count", miss_count, 16'h0);
        MEM_R_EN = 1'b0;
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
        last_rdata = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulusRead(32'h400, 1, 64'hCAFE_F00D_DEAD_BEEF);
        checkOutput("rst_refetch_rdata", rdata, 32'hDEAD_BEEF);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 60)
                applyStimulusRead(randAddr(), $urandom_range(0, 3), {$urandom, $urandom});
            else
                applyStimulusWrite(randAddr(), $urandom, $urandom_range(0, 3), r >= 90);
            if ($urandom_range(0, 3) == 0)
                idleCheck();
        end
        idleCheck();

`ifdef CACHE_STATS_EN
        exp_hits = mhits;
        exp_miss = mmiss;
`else
        exp_hits = 0;
        exp_miss = 0;
`endif
        checkOutput("final_hit_count", hit_count, exp_hits[15:0]);
        checkOutput("final_miss_count", miss_count, exp_miss[15:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
